// File: rtl/sid_bus_responder.sv
// SID register-interface target on clk32: write regs, read mux, data-bus decay latch.
// Latency: commits on the clk32 edge seeing phi2 fall with CS low; strobes one cycle later.
// Backpressure: none; the bus frame timing is owned by the bridge, one commit per CS assertion.
module sid_bus_responder #(
    parameter int DECAY_CYCLES = 2000
) (
    input  logic         clk32,
    input  logic         rst_n,
    input  logic         sid_clk,
    input  logic         sid_rst,
    input  logic         sid_cs,
    input  logic         sid_wr,
    input  logic [4:0]   sid_a,
    inout  wire  [7:0]   sid_d,
    input  logic [7:0]   potx,
    input  logic [7:0]   poty,
    input  logic [7:0]   osc3,
    input  logic [7:0]   env3,
    output logic [199:0] regs,
    output logic         wr_stb,
    output logic [4:0]   wr_addr,
    output logic [7:0]   wr_data,
    output logic         rd_stb
);

    localparam int CW = $clog2(DECAY_CYCLES + 1);
    localparam logic [CW-1:0] DECAY_MAX  = CW'(DECAY_CYCLES);
    localparam logic [CW-1:0] DECAY_LAST = CW'(DECAY_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} st_t;

    st_t           st;
    logic          sid_clk_q;
    logic [7:0]    rd_q;
    logic [7:0]    rd_mux;
    logic [7:0]    decay_latch;
    logic [CW-1:0] decay_cnt;
    logic          phi2_fall;
    logic          commit;

    assign phi2_fall = sid_clk_q & ~sid_clk;
    // DONE blocks any further phi2 falls within the same CS assertion
    assign commit    = phi2_fall & ~sid_cs & (st != DONE);

    assign sid_d = (rst_n && sid_rst && !sid_cs && sid_wr) ? rd_q : 8'hzz;

    always_comb begin
        rd_mux = decay_latch;
        case (sid_a)
            5'h19:   rd_mux = potx;
            5'h1A:   rd_mux = poty;
            5'h1B:   rd_mux = osc3;
            5'h1C:   rd_mux = env3;
            default: rd_mux = decay_latch;
        endcase
    end

    always_ff @(posedge clk32 or negedge rst_n) begin
        if (!rst_n) begin
            regs        <= '0;
            decay_latch <= '0;
            decay_cnt   <= '0;
            rd_q        <= '0;
            wr_stb      <= 1'b0;
            rd_stb      <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            st          <= IDLE;
            sid_clk_q   <= 1'b0;
        end else if (!sid_rst) begin
            regs        <= '0;
            decay_latch <= '0;
            decay_cnt   <= '0;
            rd_q        <= '0;
            wr_stb      <= 1'b0;
            rd_stb      <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            st          <= IDLE;
            sid_clk_q   <= 1'b0;
        end else begin
            sid_clk_q <= sid_clk;
            rd_q      <= rd_mux;
            wr_stb    <= 1'b0;
            rd_stb    <= 1'b0;

            case (st)
                IDLE:    if (commit) st <= DONE; else if (!sid_cs) st <= ACTIVE;
                ACTIVE:  if (sid_cs) st <= IDLE; else if (commit) st <= DONE;
                DONE:    if (sid_cs) st <= IDLE;
                default: st <= IDLE;
            endcase

            if (commit) begin
                decay_cnt <= '0;
                if (!sid_wr) begin
                    decay_latch <= sid_d;
                    if (sid_a <= 5'h18) begin
                        regs[{sid_a, 3'b000} +: 8] <= sid_d;
                        wr_stb  <= 1'b1;
                        wr_addr <= sid_a;
                        wr_data <= sid_d;
                    end
                end else begin
                    // rd_q is exactly what the bridge sampled on this edge
                    decay_latch <= rd_q;
                    rd_stb      <= 1'b1;
                end
            end else if (phi2_fall && decay_cnt != DECAY_MAX) begin
                decay_cnt <= decay_cnt + 1'b1;
                if (decay_cnt == DECAY_LAST) decay_latch <= 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_sid_bus_responder.sv
// Randomised bench for sid_bus_responder: spec-level model feeds scoreboard queues, monitor checks strobes.
module tb_sid_bus_responder;

    localparam int DECAY = 4;

    logic         clk32   = 1'b0;
    logic         rst_n   = 1'b0;
    logic         sid_clk = 1'b0;
    logic         sid_rst = 1'b1;
    logic         sid_cs  = 1'b1;
    logic         sid_wr  = 1'b1;
    logic [4:0]   sid_a   = '0;
    logic [7:0]   potx = '0, poty = '0, osc3 = '0, env3 = '0;
    wire  [7:0]   sid_d;
    logic [7:0]   tb_d   = '0;
    logic         tb_drv = 1'b0;
    logic [199:0] regs;
    logic         wr_stb, rd_stb;
    logic [4:0]   wr_addr;
    logic [7:0]   wr_data;

    assign sid_d = tb_drv ? tb_d : 8'hzz;
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (sid_d[i]);
    end

    sid_bus_responder #(.DECAY_CYCLES(DECAY)) dut (
        .clk32(clk32), .rst_n(rst_n), .sid_clk(sid_clk), .sid_rst(sid_rst),
        .sid_cs(sid_cs), .sid_wr(sid_wr), .sid_a(sid_a), .sid_d(sid_d),
        .potx(potx), .poty(poty), .osc3(osc3), .env3(env3),
        .regs(regs), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data), .rd_stb(rd_stb)
    );

    int checks = 0;
    int errors = 0;

    // reference model: register array, last bus value, phi2-fall bookkeeping
    logic [4:0] ph = '0;
    int         falls = 0;
    int         last_commit = 0;
    logic [7:0] mem [25];
    logic [7:0] m_latch = '0;
    logic [7:0] rd_sample = '0;

    typedef struct packed {logic [4:0] a; logic [7:0] d;} wexp_t;
    wexp_t      wq [$];
    logic [7:0] rq [$];

    initial forever #5 clk32 = ~clk32;

    initial forever begin
        @(negedge clk32);
        ph = ph + 1'b1;
        sid_clk = ph[4];
        if (ph == 5'd0) falls++;
    end

    task automatic tick();
        @(negedge clk32);
        #1;
    endtask

    task automatic wait_ph(input logic [4:0] v);
        tick();
        while (ph != v) tick();
    endtask

    task automatic idle(input int n);
        repeat (n) wait_ph(5'd0);
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [199:0] act, input logic [199:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [199:0] model_regs();
        logic [199:0] r;
        r = '0;
        for (int i = 0; i < 25; i++) r[8*i +: 8] = mem[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 25; i++) mem[i] = 8'h00;
        m_latch = 8'h00;
        last_commit = falls;
    endtask

    // One bus frame: CS low at phase 20, held over nfall phi2 falls, released just after.
    task automatic access(input bit w, input logic [4:0] a, input logic [7:0] d,
                          input bit probe = 1'b0, input int nfall = 1);
        logic [7:0] v;
        v = 8'h00;
        wait_ph(5'd20);
        if (w) begin
            if (a <= 5'h18) begin
                mem[a] = d;
                wq.push_back('{a: a, d: d});
            end
            m_latch = d;
        end else begin
            if      (a == 5'h19) v = potx;
            else if (a == 5'h1A) v = poty;
            else if (a == 5'h1B) v = osc3;
            else if (a == 5'h1C) v = env3;
            else if (falls - last_commit >= DECAY) v = 8'h00;
            else v = m_latch;
            rq.push_back(v);
            m_latch = v;
        end
        last_commit = falls + 1;
        sid_cs = 1'b0; sid_wr = !w; sid_a = a; tb_d = d; tb_drv = w;
        if (probe && !w) begin
            tick();
            chk8("bus_drive_1clk_after_cs", sid_d, v);
        end
        wait_ph(5'd0);
        if (!w) rd_sample = sid_d;
        repeat (nfall - 1) wait_ph(5'd0);
        tick();
        sid_cs = 1'b1; sid_wr = 1'b1; tb_drv = 1'b0;
        if (probe) begin
            #1;
            chk8("bus_release_hiz", sid_d, 8'hFF);
        end
    endtask

    // monitor: every strobe must match the oldest outstanding expectation
    initial forever begin
        wexp_t e;
        logic [7:0] r;
        tick();
        if (wr_stb) begin
            if (wq.size() == 0) begin
                checks++; errors++;
                $display("FAIL wr_stb_unexpected: got addr %h data %h expected no write", wr_addr, wr_data);
            end else begin
                e = wq.pop_front();
                chk8("wr_addr", {3'b000, wr_addr}, {3'b000, e.a});
                chk8("wr_data", wr_data, e.d);
                chk8("regs_field", regs[8*e.a +: 8], e.d);
            end
        end
        if (rd_stb) begin
            if (rq.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_stb_unexpected: got read strobe expected none");
            end else begin
                r = rq.pop_front();
                chk8("read_data", rd_sample, r);
            end
        end
    end

    initial begin
        bit         w;
        logic [4:0] a;
        logic [7:0] d;
        model_reset();
        repeat (3) tick();
        chkw("reset_regs", regs, 200'h0);
        chk8("reset_wr_stb", {7'h0, wr_stb}, 8'h00);
        chk8("reset_rd_stb", {7'h0, rd_stb}, 8'h00);
        chk8("reset_wr_addr", {3'b000, wr_addr}, 8'h00);
        chk8("reset_wr_data", wr_data, 8'h00);
        chk8("reset_bus_hiz", sid_d, 8'hFF);
        rst_n = 1'b1;
        repeat (2) tick();

        access(1'b1, 5'h18, 8'h0F);
        potx = 8'hA5;
        access(1'b0, 5'h19, 8'h00, 1'b1);
        chk8("potx_read", rd_sample, 8'hA5);

        access(1'b1, 5'h00, 8'h3C);
        access(1'b0, 5'h05, 8'h00);
        chk8("write_only_reads_latch", rd_sample, 8'h3C);
        chkw("regs_after_reg0_write", regs, model_regs());

        access(1'b1, 5'h1D, 8'h77);
        idle(3);
        access(1'b0, 5'h1E, 8'h00);
        chk8("decay_3_falls", rd_sample, 8'h77);
        access(1'b1, 5'h1D, 8'h77);
        idle(4);
        access(1'b0, 5'h1E, 8'h00);
        chk8("decay_4_falls", rd_sample, 8'h00);

        // CS pulse entirely inside phi2-high: nothing commits
        wait_ph(5'd18);
        sid_cs = 1'b0; sid_wr = 1'b0; sid_a = 5'h03; tb_d = 8'h55; tb_drv = 1'b1;
        wait_ph(5'd26);
        sid_cs = 1'b1; sid_wr = 1'b1; tb_drv = 1'b0;
        idle(2);
        chkw("regs_after_short_cs", regs, model_regs());
        access(1'b1, 5'h07, 8'h81, 1'b0, 2);
        chkw("regs_after_long_cs", regs, model_regs());

        // sid_rst during a write frame
        wait_ph(5'd20);
        sid_cs = 1'b0; sid_wr = 1'b0; sid_a = 5'h02; tb_d = 8'h99; tb_drv = 1'b1;
        wait_ph(5'd25);
        sid_rst = 1'b0;
        wait_ph(5'd0);
        tick();
        sid_cs = 1'b1; sid_wr = 1'b1; tb_drv = 1'b0; sid_rst = 1'b1;
        model_reset();
        tick();
        chkw("regs_after_sid_rst", regs, 200'h0);
        access(1'b1, 5'h04, 8'h42);

        // rst_n during a read frame
        wait_ph(5'd20);
        sid_cs = 1'b0; sid_wr = 1'b1; sid_a = 5'h19;
        wait_ph(5'd22);
        chk8("bus_before_rst_n", sid_d, 8'hA5);
        rst_n = 1'b0;
        #1;
        chk8("bus_hiz_on_rst_n", sid_d, 8'hFF);
        wait_ph(5'd0);
        tick();
        sid_cs = 1'b1;
        rst_n = 1'b1;
        model_reset();
        chkw("regs_after_rst_n", regs, 200'h0);

        for (int i = 0; i < 120; i++) begin
            potx = 8'($urandom); poty = 8'($urandom);
            osc3 = 8'($urandom); env3 = 8'($urandom);
            idle(int'($urandom_range(0, 5)));
            w = 1'($urandom);
            a = 5'($urandom_range(0, 31));
            d = 8'($urandom);
            access(w, a, d);
        end

        repeat (3) tick();
        chk8("write_queue_drained", 8'(wq.size()), 8'd0);
        chk8("read_queue_drained", 8'(rq.size()), 8'd0);
        chkw("final_regs", regs, model_regs());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
